// File: rtl/peb_ram_pkg.sv
// Shared definitions for the banked weight SRAM: address field extraction and macro constants.
// Combinational helpers only; no state.
package peb_ram_pkg;

    localparam int STARVE_MAX_DEF = 3;
    localparam int WEB_W          = 16;

    // Word-interleaved: low bits pick the bank, the rest pick the row inside it.
    function automatic int unsigned bank_idx(input logic [31:0] addr, input int unsigned bank_bit);
        return addr & ((32'd1 << bank_bit) - 32'd1);
    endfunction

    function automatic int unsigned row_idx(input logic [31:0] addr, input int unsigned bank_bit);
        return addr >> bank_bit;
    endfunction

endpackage

// File: rtl/sp_sram_bank.sv
// One single-port SYLA55 weight macro (behavioural), optional half-cycle input skew for sim timing.
// Read data registered: DO valid the cycle after a read with csb=0; DO holds between reads.
module sp_sram_bank
    import peb_ram_pkg::*;
#(
    parameter int ROW_BIT    = 6,
    parameter int SRAM_WIDTH = 28,
    parameter bit DELAY_SRAM = 1'b0
) (
    input  logic                  clk,
    input  logic                  csb,
    input  logic [WEB_W-1:0]      web,
    input  logic [ROW_BIT-1:0]    addr,
    input  logic [SRAM_WIDTH-1:0] di,
    output logic [SRAM_WIDTH-1:0] dout
);

    logic                  m_csb;
    logic [WEB_W-1:0]      m_web;
    logic [ROW_BIT-1:0]    m_addr;
    logic [SRAM_WIDTH-1:0] m_di;

    generate
        if (DELAY_SRAM) begin : g_skew
            // Capture on the falling edge so the macro sees inputs half a period late.
            logic                  csb_q;
            logic [WEB_W-1:0]      web_q;
            logic [ROW_BIT-1:0]    addr_q;
            logic [SRAM_WIDTH-1:0] di_q;
            always_ff @(negedge clk) begin
                csb_q  <= csb;
                web_q  <= web;
                addr_q <= addr;
                di_q   <= di;
            end
            assign m_csb  = csb_q;
            assign m_web  = web_q;
            assign m_addr = addr_q;
            assign m_di   = di_q;
        end else begin : g_direct
            assign m_csb  = csb;
            assign m_web  = web;
            assign m_addr = addr;
            assign m_di   = di;
        end
    endgenerate

    logic [SRAM_WIDTH-1:0] mem [2**ROW_BIT];
    logic [SRAM_WIDTH-1:0] dout_d, dout_q;

    always_comb begin
        dout_d = dout_q;
        if (!m_csb && (m_web != '0)) begin
            dout_d = mem[m_addr];
        end
    end

    always_ff @(posedge clk) begin
        dout_q <= dout_d;
        if (!m_csb && (m_web == '0)) begin
            mem[m_addr] <= m_di;
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/ram_wei_banked_wrap.sv
// Banked weight SRAM: write and read to different banks proceed together; same-bank conflicts favour write.
// Read latency 1, rd_data held between reads; a starved read is forced through after STARVE_MAX write wins.
module ram_wei_banked_wrap
    import peb_ram_pkg::*;
#(
    parameter int NUM_BANK   = 2,
    parameter int BANK_BIT   = 1,
    parameter int ROW_BIT    = 6,
    parameter int ADDR_BIT   = 7,
    parameter int SRAM_WIDTH = 28,
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter bit DELAY_SRAM = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_BIT-1:0]   wr_addr,
    input  logic [SRAM_WIDTH-1:0] wr_data,
    input  logic                  rd_valid,
    output logic                  rd_ready,
    input  logic [ADDR_BIT-1:0]   rd_addr,
    output logic                  rd_dvalid,
    output logic [SRAM_WIDTH-1:0] rd_data
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [BANK_BIT-1:0]   wr_bank, rd_bank;
    logic [ROW_BIT-1:0]    wr_row, rd_row;
    logic                  conflict, read_wins;
    logic                  wr_acc, rd_acc;

    logic [CNT_W-1:0]      starve_cnt_d, starve_cnt_q;
    logic                  rd_pend_d, rd_pend_q;
    logic [BANK_BIT-1:0]   rd_bank_d, rd_bank_q;
    logic [SRAM_WIDTH-1:0] rd_hold_d, rd_hold_q;

    logic [NUM_BANK-1:0]   bank_wr_sel, bank_rd_sel, bank_csb;
    logic [WEB_W-1:0]      bank_web  [NUM_BANK];
    logic [ROW_BIT-1:0]    bank_addr [NUM_BANK];
    logic [SRAM_WIDTH-1:0] bank_do   [NUM_BANK];

    always_comb begin
        wr_bank   = BANK_BIT'(bank_idx(32'(wr_addr), BANK_BIT));
        rd_bank   = BANK_BIT'(bank_idx(32'(rd_addr), BANK_BIT));
        wr_row    = ROW_BIT'(row_idx(32'(wr_addr), BANK_BIT));
        rd_row    = ROW_BIT'(row_idx(32'(rd_addr), BANK_BIT));
        conflict  = wr_valid && rd_valid && (wr_bank == rd_bank);
        read_wins = conflict && (starve_cnt_q == CNT_W'(STARVE_MAX));
        wr_ready  = !rst && !read_wins;
        rd_ready  = !rst && !(conflict && !read_wins);
        wr_acc    = wr_valid && wr_ready;
        rd_acc    = rd_valid && rd_ready;

        // Only a lost read keeps the count alive; anything else restarts it.
        starve_cnt_d = '0;
        if (conflict && !read_wins) begin
            starve_cnt_d = (starve_cnt_q == CNT_W'(STARVE_MAX)) ? starve_cnt_q
                                                                : starve_cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        bank_wr_sel = '0;
        bank_rd_sel = '0;
        bank_csb    = '1;
        bank_web    = '{default: '1};
        bank_addr   = '{default: '0};
        for (int b = 0; b < NUM_BANK; b++) begin
            bank_wr_sel[b] = wr_acc && (wr_bank == BANK_BIT'(b));
            bank_rd_sel[b] = rd_acc && (rd_bank == BANK_BIT'(b));
            bank_csb[b]    = !(bank_wr_sel[b] || bank_rd_sel[b]);
            bank_web[b]    = bank_wr_sel[b] ? '0 : '1;
            bank_addr[b]   = bank_wr_sel[b] ? wr_row : rd_row;
        end
    end

    always_comb begin
        rd_pend_d = rd_acc;
        rd_bank_d = rd_acc ? rd_bank : rd_bank_q;
        rd_dvalid = rd_pend_q && !rst;
        // Reset masks the output immediately, not just from the next cycle.
        rd_data   = rd_hold_q;
        if (rst) begin
            rd_data = '0;
        end else if (rd_pend_q) begin
            rd_data = bank_do[rd_bank_q];
        end
        rd_hold_d = rd_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q <= '0;
            rd_pend_q    <= 1'b0;
            rd_bank_q    <= '0;
            rd_hold_q    <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            rd_pend_q    <= rd_pend_d;
            rd_bank_q    <= rd_bank_d;
            rd_hold_q    <= rd_hold_d;
        end
    end

    generate
        for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
            sp_sram_bank #(
                .ROW_BIT    (ROW_BIT),
                .SRAM_WIDTH (SRAM_WIDTH),
                .DELAY_SRAM (DELAY_SRAM)
            ) u_bank (
                .clk  (clk),
                .csb  (bank_csb[b]),
                .web  (bank_web[b]),
                .addr (bank_addr[b]),
                .di   (wr_data),
                .dout (bank_do[b])
            );
        end
    endgenerate

endmodule

// File: tb/tb_ram_wei_banked_wrap.sv
// Directed bench for the banked weight SRAM wrapper with hand-computed expectations.
module tb_ram_wei_banked_wrap;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_valid, wr_ready;
    logic [6:0]  wr_addr;
    logic [27:0] wr_data;
    logic        rd_valid, rd_ready;
    logic [6:0]  rd_addr;
    logic        rd_dvalid;
    logic [27:0] rd_data;

    int n_chk = 0;
    int n_err = 0;
    logic [27:0] model [128];

    always #5 clk = ~clk;

    ram_wei_banked_wrap dut (
        .clk       (clk),
        .rst       (rst),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_addr   (rd_addr),
        .rd_dvalid (rd_dvalid),
        .rd_data   (rd_data)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle's inputs just after the edge, then stop at the falling edge for checks.
    task automatic cycle(input bit wv, input logic [6:0] wa, input logic [27:0] wd,
                         input bit rv, input logic [6:0] ra);
        @(posedge clk);
        #1;
        wr_valid = wv;
        wr_addr  = wa;
        wr_data  = wd;
        rd_valid = rv;
        rd_addr  = ra;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int npulse;
        logic [27:0] v;
        rst = 1'b1;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        rd_valid = 1'b0; rd_addr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_dvalid", 32'(rd_dvalid), 32'd0);
        chk("rst_data",   32'(rd_data),   32'd0);
        chk("rst_wr_rdy", 32'(wr_ready),  32'd0);
        chk("rst_rd_rdy", 32'(rd_ready),  32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("idle_wr_rdy", 32'(wr_ready), 32'd1);
        chk("idle_rd_rdy", 32'(rd_ready), 32'd1);
        chk("idle_starve", 32'(dut.starve_cnt_q), 32'd0);

        // Basic write/read-back and hold
        cycle(1, 7'h00, 28'hABCDEF0, 0, 7'h00);
        chk("w0_rdy", 32'(wr_ready), 32'd1);
        cycle(1, 7'h01, 28'h1234567, 0, 7'h00);
        cycle(0, 7'h00, 28'h0, 1, 7'h00);
        chk("r0_rdy", 32'(rd_ready), 32'd1);
        chk("r0_no_dvalid", 32'(rd_dvalid), 32'd0);
        cycle(0, 7'h00, 28'h0, 1, 7'h01);
        chk("r0_dvalid", 32'(rd_dvalid), 32'd1);
        chk("r0_data",   32'(rd_data),   32'h0ABCDEF0);
        cycle(0, 7'h00, 28'h0, 0, 7'h00);
        chk("r1_dvalid", 32'(rd_dvalid), 32'd1);
        chk("r1_data",   32'(rd_data),   32'h01234567);
        cycle(0, 7'h00, 28'h0, 0, 7'h00);
        chk("hold_dvalid", 32'(rd_dvalid), 32'd0);
        chk("hold_data",   32'(rd_data),   32'h01234567);

        // Write bank0 and read bank1 in the same cycle
        cycle(1, 7'h02, 28'h0000222, 1, 7'h01);
        chk("dual_wr_rdy", 32'(wr_ready), 32'd1);
        chk("dual_rd_rdy", 32'(rd_ready), 32'd1);
        cycle(0, 7'h00, 28'h0, 1, 7'h02);
        chk("dual_dvalid", 32'(rd_dvalid), 32'd1);
        chk("dual_data",   32'(rd_data),   32'h01234567);
        cycle(0, 7'h00, 28'h0, 0, 7'h00);
        chk("dual_w_data", 32'(rd_data),   32'h00000222);

        // Same-bank conflict: write wins three times, then the read is forced
        cycle(1, 7'h06, 28'h0000666, 0, 7'h00);
        for (int k = 0; k < 4; k++) begin
            cycle(1, 7'h04, 28'h0000044, 1, 7'h06);
            chk($sformatf("cf_starve%0d", k), 32'(dut.starve_cnt_q), 32'(k));
            chk($sformatf("cf_rd_rdy%0d", k), 32'(rd_ready), (k < 3) ? 32'd0 : 32'd1);
            chk($sformatf("cf_wr_rdy%0d", k), 32'(wr_ready), (k < 3) ? 32'd1 : 32'd0);
        end
        cycle(0, 7'h00, 28'h0, 0, 7'h00);
        chk("cf_starve_clr", 32'(dut.starve_cnt_q), 32'd0);
        chk("cf_dvalid",     32'(rd_dvalid), 32'd1);
        chk("cf_data",       32'(rd_data),   32'h00000666);

        // Write then read of the same address on consecutive cycles
        cycle(1, 7'h10, 28'h5A5A5A5, 0, 7'h00);
        cycle(0, 7'h00, 28'h0, 1, 7'h10);
        cycle(0, 7'h00, 28'h0, 0, 7'h00);
        chk("raw_dvalid", 32'(rd_dvalid), 32'd1);
        chk("raw_data",   32'(rd_data),   32'h05A5A5A5);

        // Reset with a read in flight
        cycle(0, 7'h00, 28'h0, 1, 7'h00);
        @(posedge clk);
        #1 rst = 1'b1;
        rd_valid = 1'b0;
        @(negedge clk);
        chk("rstf_dvalid", 32'(rd_dvalid), 32'd0);
        chk("rstf_data",   32'(rd_data),   32'd0);
        chk("rstf_rd_rdy", 32'(rd_ready),  32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rstf_drop_dvalid", 32'(rd_dvalid), 32'd0);
        chk("rstf_drop_data",   32'(rd_data),   32'd0);
        cycle(0, 7'h00, 28'h0, 1, 7'h10);
        cycle(0, 7'h00, 28'h0, 0, 7'h00);
        chk("rstf_mem_kept", 32'(rd_data), 32'h05A5A5A5);

        // Fill 0..63, then 64 back-to-back reads alternating banks
        for (int i = 0; i < 64; i++) begin
            v = 28'(i * 32'h0123457 + 32'h0F00001);
            model[i] = v;
            cycle(1, 7'(i), v, 0, 7'h00);
        end
        npulse = 0;
        for (int i = 0; i < 64; i++) begin
            cycle(0, 7'h00, 28'h0, 1, 7'(i));
            chk($sformatf("b2b_rdy%0d", i), 32'(rd_ready), 32'd1);
            if (i > 0) begin
                chk($sformatf("b2b_dvalid%0d", i - 1), 32'(rd_dvalid), 32'd1);
                chk($sformatf("b2b_data%0d", i - 1), 32'(rd_data), 32'(model[i - 1]));
            end
            if (rd_dvalid) npulse++;
        end
        cycle(0, 7'h00, 28'h0, 0, 7'h00);
        chk("b2b_dvalid63", 32'(rd_dvalid), 32'd1);
        chk("b2b_data63",   32'(rd_data),   32'(model[63]));
        if (rd_dvalid) npulse++;
        chk("b2b_pulses", 32'(npulse), 32'd64);
        cycle(0, 7'h00, 28'h0, 0, 7'h00);
        chk("b2b_end_dvalid", 32'(rd_dvalid), 32'd0);
        chk("b2b_end_hold",   32'(rd_data),   32'(model[63]));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
